bp_me_stream_to_burst_buffered: RTL and testbench
=================================================

# bp_me_stream_to_burst_buffered

Converts a BedRock Stream message into BedRock Burst (separate header and data channels), with decoupled flow control on each output channel. A registered header slot and a parametrised data FIFO let the header and data channels drain independently; header and data never need to be accepted in lockstep. It sits at the boundary between Stream-protocol producers (e.g. cache engines) and Burst-protocol consumers (memory / IO links), and replaces the unbuffered pass-through converter wherever the consumer's header and data ready signals are independent.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- data_width_p, none (must be set): width of one data beat.
- payload_width_p, none (must be set): BedRock header payload width.
- payload_mask_p, 0: bit i set means msg_type i carries data.
- data_els_p, 2: data FIFO depth in beats; legal values are ≥2.

Ports:
- clk_i  in  1  clock. One clock domain only.
- reset_i  in  1  reset; synchronous, active-high.
- in_msg_header_i  in  bp_header_width_lp  Stream header; valid on every beat of a message.
- in_msg_data_i  in  data_width_p  Stream data beat.
- in_msg_v_i  in  1  input beat valid.
- in_msg_last_i  in  1  last beat of the message.
- in_msg_ready_and_o  out  1  input beat accepted when this and in_msg_v_i are both high.
- out_msg_header_o  out  bp_header_width_lp  Burst header, taken from the header slot.
- out_msg_header_v_o  out  1  Burst header valid.
- out_msg_has_data_o  out  1  payload_mask_p[msg_type] of the header in the slot.
- out_msg_header_ready_and_i  in  1  header consumer ready.
- out_msg_data_o  out  data_width_p  Burst data beat (FIFO head).
- out_msg_data_v_o  out  1  Burst data valid.
- out_msg_last_o  out  1  last-beat flag stored alongside the FIFO head.
- out_msg_data_ready_and_i  in  1  data consumer ready.

## Operation
- State:
  - first_r: set means the next input beat is a message's first beat. Reset value is 1.
  - hdr_v_r, hdr_r: the header slot.
  - draining_r: a data-carrying header has been sent and its last data beat has not yet left.
  - Data FIFO: data_els_p entries, each {last, data}.
- Input acceptance:
  - First beat (first_r=1): in_msg_ready_and_o = ~hdr_v_r & ~fifo_full. It does not depend on the header contents or on in_msg_v_i.
  - Later beats: in_msg_ready_and_o = ~fifo_full.
- On an accepted first beat:
  - Load hdr_r and set hdr_v_r.
  - If has_data, push {in_msg_last_i, in_msg_data_i} into the FIFO.
  - A message without data is exactly one beat with last=1. Its data is dropped and nothing is pushed.
- On an accepted later beat: push {last, data}.
- first_r updates on every accepted beat: first_r <= in_msg_last_i.
- Header output:
  - out_msg_header_v_o = hdr_v_r & ~draining_r, so the previous message's data fully drains before the next header issues.
  - On a header handshake: clear hdr_v_r, and set draining_r if has_data.
- Data output:
  - out_msg_data_v_o = fifo_v & draining_r.
  - On a data handshake with last=1, clear draining_r.
- The FIFO may hold data of message N (draining) followed by message N+1, whose header waits in the slot. Ordering is preserved by FIFO order and the draining_r gate.
- Simultaneous events:
  - A header handshake and a new first-beat accept in the same cycle cannot occur: the first-beat accept requires hdr_v_r=0.
  - A FIFO push and pop in the same cycle are both legal when not full.
  - A full FIFO blocks input even if a pop occurs that cycle; there is no ready bypass.
  - If draining_r's set and clear fire in the same cycle, clear wins. This case is unreachable by construction but must be coded that way.

## Timing
- Reset values:
  - in_msg_ready_and_o=0 while reset_i is high.
  - out_msg_header_v_o=0, out_msg_data_v_o=0.
  - first_r=1, hdr_v_r=0, draining_r=0, FIFO empty.
  - Reset mid-message discards every in-flight header and beat. The next beat after reset is treated as a first beat.
- Latency:
  - Header is valid the cycle after its input beat is accepted.
  - A data beat is valid no earlier than 1 cycle after push and 1 cycle after its header handshake.
  - There is no combinational path from input to output.
- Throughput: with both consumers always ready and data_els_p≥2, one data beat per cycle is sustained after the header.
- All outputs are functions of registers only. in_msg_ready_and_o depends on first_r, hdr_v_r, fifo_full and reset_i.

## Test plan
- No-data message (msg_type not in mask, last=1), all readies high:
  - Header valid 1 cycle after accept, has_data=0.
  - No data valid ever.
  - Input ready returns next cycle.
- 4-beat data message, data 0xA..0xD, both readies high:
  - Header 1 cycle after the first accept.
  - Data 0xA–0xD on consecutive cycles, last only on 0xD.
  - draining_r clears after 0xD.
- Header ready held low 5 cycles, data_els_p=2, 4-beat message:
  - Input accepts 2 beats, then ready=0 (FIFO full).
  - No data valid before the header handshake.
  - All 4 beats then arrive in order.
- Back-to-back 2-beat messages, data ready low for 3 cycles after header 1 is sent:
  - Header 2 is held (header_v=0) until message 1's last beat leaves.
  - Data order is 1a,1b,2a,2b.
- Random ready toggling on both output channels, 200 mixed messages: scoreboard confirms
  - every header precedes its data;
  - beat counts and last flags match;
  - no data appears for no-data messages.
- Reset asserted during beat 2 of a 4-beat message:
  - Outputs go invalid the next cycle, FIFO empty, first_r=1.
  - A fresh message after reset converts correctly.

Source files
------------

// File: rtl/bp_me_stream_to_burst_buffered.sv
// Stream-to-Burst converter with a registered header slot and a data FIFO so
// the Burst header and data channels drain independently of each other.
//
// Header layout (LSB first): msg_type[3:0], subop[3:0], addr, size[2:0], payload.
// Only msg_type is interpreted here; the remaining fields pass through untouched.
module bp_me_stream_to_burst_buffered #(
  parameter int          paddr_width_p   = 40,
  parameter int          data_width_p    = 64,
  parameter int          payload_width_p = 16,
  parameter logic [15:0] payload_mask_p  = 16'h0000,
  parameter int          data_els_p      = 2,
  localparam int msg_type_width_lp  = 4,
  localparam int bp_header_width_lp = msg_type_width_lp + 4 + paddr_width_p + 3 + payload_width_p
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [bp_header_width_lp-1:0] in_msg_header_i,
  input  logic [data_width_p-1:0]       in_msg_data_i,
  input  logic                          in_msg_v_i,
  input  logic                          in_msg_last_i,
  output logic                          in_msg_ready_and_o,

  output logic [bp_header_width_lp-1:0] out_msg_header_o,
  output logic                          out_msg_header_v_o,
  output logic                          out_msg_has_data_o,
  input  logic                          out_msg_header_ready_and_i,

  output logic [data_width_p-1:0]       out_msg_data_o,
  output logic                          out_msg_data_v_o,
  output logic                          out_msg_last_o,
  input  logic                          out_msg_data_ready_and_i
);

  localparam int ptrWidthLp = (data_els_p > 1) ? $clog2(data_els_p) : 1;
  localparam int cntWidthLp = $clog2(data_els_p + 1);

  // Header slot and message tracking
  logic                          first_q, first_d;
  logic                          hdrValid_q, hdrValid_d;
  logic [bp_header_width_lp-1:0] hdr_q, hdr_d;
  logic                          draining_q, draining_d;

  // Data FIFO: each entry is {last, data}
  logic [data_width_p:0]         fifoMem_q [data_els_p];
  logic [ptrWidthLp-1:0]         wrPtr_q, wrPtr_d;
  logic [ptrWidthLp-1:0]         rdPtr_q, rdPtr_d;
  logic [cntWidthLp-1:0]         count_q, count_d;

  logic fifoFull, fifoValid;
  logic inHasData, slotHasData;
  logic inAccept, fifoPush, fifoPop, hdrHandshake;
  logic headLast;

  function automatic logic [ptrWidthLp-1:0] nextPtr(input logic [ptrWidthLp-1:0] ptr);
    if (ptr == ptrWidthLp'(data_els_p - 1)) begin
      return '0;
    end
    return ptr + ptrWidthLp'(1);
  endfunction

  assign fifoFull    = (count_q == cntWidthLp'(data_els_p));
  assign fifoValid   = (count_q != '0);
  assign inHasData   = payload_mask_p[in_msg_header_i[msg_type_width_lp-1:0]];
  assign slotHasData = payload_mask_p[hdr_q[msg_type_width_lp-1:0]];
  assign headLast    = fifoMem_q[rdPtr_q][data_width_p];

  // A first beat also needs the header slot free; a full FIFO always stalls input,
  // even when a pop happens in the same cycle.
  assign in_msg_ready_and_o = ~reset_i & ~fifoFull & (~first_q | ~hdrValid_q);
  assign inAccept           = in_msg_ready_and_o & in_msg_v_i;
  assign fifoPush           = inAccept & (~first_q | inHasData);

  // The next header waits until the previous message's data has fully left.
  assign out_msg_header_o   = hdr_q;
  assign out_msg_header_v_o = hdrValid_q & ~draining_q;
  assign out_msg_has_data_o = slotHasData;
  assign hdrHandshake       = out_msg_header_v_o & out_msg_header_ready_and_i;

  assign out_msg_data_o     = fifoMem_q[rdPtr_q][data_width_p-1:0];
  assign out_msg_last_o     = headLast;
  assign out_msg_data_v_o   = fifoValid & draining_q;
  assign fifoPop            = out_msg_data_v_o & out_msg_data_ready_and_i;

  // Next-state logic for the header slot, draining flag and FIFO bookkeeping
  always_comb begin
    first_d    = first_q;
    hdrValid_d = hdrValid_q;
    hdr_d      = hdr_q;
    draining_d = draining_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;

    if (inAccept) begin
      first_d = in_msg_last_i;
    end

    if (inAccept && first_q) begin
      hdr_d      = in_msg_header_i;
      hdrValid_d = 1'b1;
    end else if (hdrHandshake) begin
      hdrValid_d = 1'b0;
    end

    if (fifoPop && headLast) begin
      draining_d = 1'b0;
    end else if (hdrHandshake && slotHasData) begin
      draining_d = 1'b1;
    end

    if (fifoPush) begin
      wrPtr_d = nextPtr(wrPtr_q);
    end
    if (fifoPop) begin
      rdPtr_d = nextPtr(rdPtr_q);
    end

    case ({fifoPush, fifoPop})
      2'b10:   count_d = count_q + cntWidthLp'(1);
      2'b01:   count_d = count_q - cntWidthLp'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset; reset discards in-flight messages
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      first_q    <= 1'b1;
      hdrValid_q <= 1'b0;
      hdr_q      <= '0;
      draining_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      first_q    <= first_d;
      hdrValid_q <= hdrValid_d;
      hdr_q      <= hdr_d;
      draining_q <= draining_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset; the pointers and count define what is valid
  always_ff @(posedge clk_i) begin
    if (fifoPush) begin
      fifoMem_q[wrPtr_q] <= {in_msg_last_i, in_msg_data_i};
    end
  end

endmodule

// File: tb/tb_bp_me_stream_to_burst_buffered.sv
// Scoreboard bench for bp_me_stream_to_burst_buffered: directed scenarios plus
// randomized traffic, with a message-level model of expected Burst output.
module tb_bp_me_stream_to_burst_buffered;

  localparam int          PaddrW   = 16;
  localparam int          DataW    = 32;
  localparam int          PayloadW = 8;
  localparam int          DataEls  = 2;
  localparam logic [15:0] Mask     = 16'h00F0;
  localparam int          HdrW     = 4 + 4 + PaddrW + 3 + PayloadW;
  localparam int          Budget   = 1000;

  typedef struct {
    logic [HdrW-1:0] hdr;
    logic            hasData;
    int              beats;
  } expHdr_t;

  typedef struct {
    logic [DataW-1:0] data;
    logic             last;
  } expBeat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [HdrW-1:0]  inHeader;
  logic [DataW-1:0] inData;
  logic             inValid;
  logic             inLast;
  logic             inReady;
  logic [HdrW-1:0]  outHeader;
  logic             hdrV;
  logic             outHasData;
  logic             hdrReady;
  logic [DataW-1:0] outData;
  logic             dataV;
  logic             outLast;
  logic             dataReady;

  expHdr_t  expHdrQ[$];
  expBeat_t expDataQ[$];
  int       hdrCycleQ[$];
  int       dataCycleQ[$];

  int          assertCount = 0;
  int          failCount = 0;
  int          cycleCount = 0;
  int          pendingBeats = 0;
  int          hdrSeen = 0;
  int          acceptedBeats = 0;
  int          firstAcceptCycle = 0;
  int          acceptBase;
  int          hdrBase;
  int          waitedB2b;
  int          acDummy;
  bit          randomMode = 1'b0;
  logic [15:0] maskBits = Mask;
  logic [HdrW-1:0] rstHdr;

  bp_me_stream_to_burst_buffered #(
    .paddr_width_p   (PaddrW),
    .data_width_p    (DataW),
    .payload_width_p (PayloadW),
    .payload_mask_p  (Mask),
    .data_els_p      (DataEls)
  ) dut (
    .clk_i                      (clk),
    .reset_i                    (reset),
    .in_msg_header_i            (inHeader),
    .in_msg_data_i              (inData),
    .in_msg_v_i                 (inValid),
    .in_msg_last_i              (inLast),
    .in_msg_ready_and_o         (inReady),
    .out_msg_header_o           (outHeader),
    .out_msg_header_v_o         (hdrV),
    .out_msg_has_data_o         (outHasData),
    .out_msg_header_ready_and_i (hdrReady),
    .out_msg_data_o             (outData),
    .out_msg_data_v_o           (dataV),
    .out_msg_last_o             (outLast),
    .out_msg_data_ready_and_i   (dataReady)
  );

  // Free-running clock and cycle counter used for latency measurements
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Watchdog so the run always ends even if the DUT deadlocks
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endfunction

  function automatic void reportFail(string name, string detail);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: %s", name, detail);
  endfunction

  function automatic logic [HdrW-1:0] makeHdr(input logic [3:0] msgType);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[3:0] = msgType;
    return r[HdrW-1:0];
  endfunction

  // Random backpressure on both output channels while randomMode is set
  always @(posedge clk) begin
    if (randomMode) begin
      #2;
      hdrReady  = ($urandom_range(0, 3) != 0);
      dataReady = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every output handshake is checked against the scoreboard queues
  always @(negedge clk) begin
    expHdr_t  eh;
    expBeat_t eb;
    if (!reset) begin
      if (hdrV && hdrReady) begin
        hdrSeen++;
        hdrCycleQ.push_back(cycleCount);
        checkOutput("hdrAfterPrevData", pendingBeats, 0);
        if (expHdrQ.size() == 0) begin
          reportFail("hdrUnexpected", $sformatf("header 0x%0h with none expected", outHeader));
        end else begin
          eh = expHdrQ.pop_front();
          checkOutput("hdrValue", outHeader, eh.hdr);
          checkOutput("hdrHasData", outHasData, eh.hasData);
          pendingBeats = eh.beats;
        end
      end
      if (dataV && dataReady) begin
        dataCycleQ.push_back(cycleCount);
        if (pendingBeats == 0 || expDataQ.size() == 0) begin
          reportFail("dataWithoutHeader", $sformatf("data 0x%0h with no open data message", outData));
        end else begin
          eb = expDataQ.pop_front();
          checkOutput("dataValue", outData, eb.data);
          checkOutput("dataLast", outLast, eb.last);
          pendingBeats--;
        end
      end
    end
  end

  task automatic driveBeat(input logic [HdrW-1:0] hdr, input logic [DataW-1:0] data,
                           input logic last, output int acceptCycle);
    int  waited;
    bit  accepted;
    waited      = 0;
    accepted    = 1'b0;
    acceptCycle = 0;
    inHeader = hdr;
    inData   = data;
    inLast   = last;
    inValid  = 1'b1;
    while (!accepted && waited < Budget) begin
      @(negedge clk);
      if (inReady) begin
        accepted    = 1'b1;
        acceptCycle = cycleCount;
        acceptedBeats++;
      end else begin
        waited++;
      end
    end
    if (!accepted) begin
      reportFail("inAcceptTimeout", "input beat never accepted");
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Issue one whole Stream message and record what the Burst side must produce
  task automatic applyStimulus(input logic [HdrW-1:0] hdr, input int nBeats,
                               input logic [DataW-1:0] base, input bit randData);
    logic             hasData;
    logic [DataW-1:0] d;
    logic             last;
    int               beats;
    int               ac;
    hasData = maskBits[hdr[3:0]];
    beats   = hasData ? nBeats : 1;
    expHdrQ.push_back('{hdr: hdr, hasData: hasData, beats: (hasData ? nBeats : 0)});
    for (int i = 0; i < beats; i++) begin
      d    = randData ? DataW'($urandom) : base + DataW'(i);
      last = (i == beats - 1);
      if (hasData) begin
        expDataQ.push_back('{data: d, last: last});
      end
      driveBeat(hdr, d, last, ac);
      if (i == 0) begin
        firstAcceptCycle = ac;
      end
    end
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    while ((expHdrQ.size() != 0 || expDataQ.size() != 0 || pendingBeats != 0) && waited < Budget) begin
      @(posedge clk);
      #2;
      waited++;
    end
    checkOutput("drainDone", (expHdrQ.size() == 0 && expDataQ.size() == 0 && pendingBeats == 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Main test sequence
  initial begin
    reset     = 1'b1;
    inValid   = 1'b0;
    inHeader  = '0;
    inData    = '0;
    inLast    = 1'b0;
    hdrReady  = 1'b1;
    dataReady = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("resetInReady", inReady, 0);
    checkOutput("resetHdrValid", hdrV, 0);
    checkOutput("resetDataValid", dataV, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postResetInReady", inReady, 1);
    @(posedge clk);
    #1;

    $display("[TB] no-data message");
    applyStimulus(makeHdr(4'h1), 1, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("noDataHdrValid", hdrV, 1);
    checkOutput("noDataHasData", outHasData, 0);
    checkOutput("noDataInBlocked", inReady, 0);
    @(negedge clk);
    checkOutput("noDataInReadyBack", inReady, 1);
    checkOutput("noDataHdrCleared", hdrV, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("noDataNoDataValid", dataV, 0);
    end
    @(posedge clk);
    #1;
    waitIdle();

    $display("[TB] four-beat message, open readies");
    hdrCycleQ.delete();
    dataCycleQ.delete();
    applyStimulus(makeHdr(4'h4), 4, 32'hA, 1'b0);
    waitIdle();
    checkOutput("fourBeatCount", dataCycleQ.size(), 4);
    checkOutput("fourBeatHdrCount", hdrCycleQ.size(), 1);
    if (hdrCycleQ.size() == 1 && dataCycleQ.size() == 4) begin
      checkOutput("fourBeatHdrLatency", hdrCycleQ[0] - firstAcceptCycle, 1);
      checkOutput("fourBeatFirstData", dataCycleQ[0] - hdrCycleQ[0], 1);
      for (int i = 1; i < 4; i++) begin
        checkOutput("fourBeatBackToBack", dataCycleQ[i] - dataCycleQ[i-1], 1);
      end
    end

    $display("[TB] header consumer stalled");
    hdrReady   = 1'b0;
    acceptBase = acceptedBeats;
    fork
      applyStimulus(makeHdr(4'h5), 4, 32'h100, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("hdrStallNoData", dataV, 0);
        end
        checkOutput("hdrStallAccepted", acceptedBeats - acceptBase, 2);
        checkOutput("hdrStallInReady", inReady, 0);
        @(posedge clk);
        #1;
        hdrReady = 1'b1;
      end
    join
    waitIdle();

    $display("[TB] back-to-back messages, data consumer stalled");
    hdrBase = hdrSeen;
    dataCycleQ.delete();
    waitedB2b = 0;
    fork
      begin
        applyStimulus(makeHdr(4'h6), 2, 32'h1A0, 1'b0);
        applyStimulus(makeHdr(4'h7), 2, 32'h2A0, 1'b0);
      end
      begin
        while (hdrSeen == hdrBase && waitedB2b < Budget) begin
          @(posedge clk);
          #2;
          waitedB2b++;
        end
        checkOutput("b2bHdr1Seen", hdrSeen - hdrBase, 1);
        dataReady = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("b2bHdr2Held", hdrV, 0);
        end
        @(posedge clk);
        #1;
        dataReady = 1'b1;
      end
    join
    waitIdle();
    checkOutput("b2bBeatCount", dataCycleQ.size(), 4);

    $display("[TB] randomized traffic");
    randomMode = 1'b1;
    for (int m = 0; m < 200; m++) begin
      applyStimulus(makeHdr(4'($urandom_range(0, 15))), $urandom_range(1, 4), '0, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    randomMode = 1'b0;
    @(posedge clk);
    #3;
    hdrReady  = 1'b1;
    dataReady = 1'b1;
    waitIdle();

    $display("[TB] reset in the middle of a message");
    rstHdr = makeHdr(4'h5);
    expHdrQ.push_back('{hdr: rstHdr, hasData: 1'b1, beats: 4});
    for (int i = 0; i < 4; i++) begin
      expDataQ.push_back('{data: 32'h300 + DataW'(i), last: (i == 3)});
    end
    driveBeat(rstHdr, 32'h300, 1'b0, acDummy);
    driveBeat(rstHdr, 32'h301, 1'b0, acDummy);
    inHeader = rstHdr;
    inData   = 32'h302;
    inLast   = 1'b0;
    inValid  = 1'b1;
    reset    = 1'b1;
    expHdrQ.delete();
    expDataQ.delete();
    pendingBeats = 0;
    @(negedge clk);
    checkOutput("midResetInReady", inReady, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midResetHdrValid", hdrV, 0);
    checkOutput("midResetDataValid", dataV, 0);
    checkOutput("midResetInReadyHeld", inReady, 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("afterResetInReady", inReady, 1);
    checkOutput("afterResetHdrValid", hdrV, 0);
    checkOutput("afterResetDataValid", dataV, 0);
    @(posedge clk);
    #1;
    dataCycleQ.delete();
    applyStimulus(makeHdr(4'h6), 3, 32'h400, 1'b0);
    waitIdle();
    checkOutput("afterResetBeatCount", dataCycleQ.size(), 3);

    checkOutput("scoreboardEmpty", expHdrQ.size() + expDataQ.size() + pendingBeats, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
